// File: rtl/clint_timer_if.sv
// Data-memory side bus between the MEM stage and the machine timer / software-interrupt block.
// Purpose: bundles request, combinational response and interrupt lines into one port.
// Ports: master = pipeline side (drives request), slave = clint_timer (drives response + irqs).
interface clint_timer_if;
    logic        mem_write;
    logic        mem_read;
    logic [3:0]  wmask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sel;
    logic [31:0] rdata;
    logic        exception;
    logic [4:0]  cause;
    logic [31:0] trap_val;
    logic        timer_irq;
    logic        soft_irq;

    modport master (
        output mem_write, mem_read, wmask, addr, wdata,
        input  sel, rdata, exception, cause, trap_val, timer_irq, soft_irq
    );

    modport slave (
        input  mem_write, mem_read, wmask, addr, wdata,
        output sel, rdata, exception, cause, trap_val, timer_irq, soft_irq
    );
endinterface

// File: rtl/clint_timer.sv
// Purpose: machine timer (64-bit mtime, mtimecmp, prescaler) and msip responder on the data-memory port.
// Latency: sel/rdata/exception/cause/trap_val combinational; writes commit on the request edge; irqs registered.
// Backpressure: none, every access completes in its own cycle.
// Ports: clk, rst (async active-low), bus (slave modport: request in, response and timer/soft irq out).
module clint_timer #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          PRESCALE_W   = 16,
    parameter int          PRESCALE_RST = 0
) (
    input  logic          clk,
    input  logic          rst,
    clint_timer_if.slave  bus
);
    localparam logic [7:0] OFF_MSIP   = 8'h00;
    localparam logic [7:0] OFF_CMP_LO = 8'h08;
    localparam logic [7:0] OFF_CMP_HI = 8'h0C;
    localparam logic [7:0] OFF_MT_LO  = 8'h10;
    localparam logic [7:0] OFF_MT_HI  = 8'h14;
    localparam logic [7:0] OFF_PRESC  = 8'h18;
    localparam logic [PRESCALE_W-1:0] CNT_ONE = PRESCALE_W'(1);

    logic                  msip_q, msip_d;
    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic                  timer_irq_q, timer_irq_d;
    logic                  soft_irq_q, soft_irq_d;

    logic [7:0]  off;
    logic        in_win, mapped, misal, sel, exc, wr_ok, tick;
    logic [31:0] rd_val;
    logic [31:0] presc_wr;

    function automatic logic [31:0] merge32(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] mask);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    // Decode, fault check and read mux.
    always_comb begin
        off    = bus.addr[7:0];
        in_win = (bus.addr[31:8] == BASE_ADDR[31:8]);
        sel    = in_win & (bus.mem_read | bus.mem_write);
        misal  = |bus.addr[1:0];
        case (off)
            OFF_MSIP, OFF_CMP_LO, OFF_CMP_HI, OFF_MT_LO, OFF_MT_HI, OFF_PRESC: mapped = 1'b1;
            default:                                                          mapped = 1'b0;
        endcase
        exc = sel & (misal | ~mapped);

        bus.sel       = sel;
        bus.exception = exc;
        bus.cause     = 5'd0;
        if (exc) begin
            // Store wins the cause encoding when both request bits are set.
            if (bus.mem_write) bus.cause = misal ? 5'd6 : 5'd7;
            else               bus.cause = misal ? 5'd4 : 5'd5;
        end
        bus.trap_val = exc ? bus.addr : 32'd0;

        case (off)
            OFF_MSIP:   rd_val = {31'd0, msip_q};
            OFF_CMP_LO: rd_val = mtimecmp_q[31:0];
            OFF_CMP_HI: rd_val = mtimecmp_q[63:32];
            OFF_MT_LO:  rd_val = mtime_q[31:0];
            OFF_MT_HI:  rd_val = mtime_q[63:32];
            OFF_PRESC:  rd_val = 32'(prescale_q);
            default:    rd_val = 32'd0;
        endcase
        bus.rdata = (sel & ~exc & bus.mem_read) ? rd_val : 32'd0;

        wr_ok = sel & bus.mem_write & ~exc & (|bus.wmask);
    end

    // Next-state: prescaler, mtime tick, register writes.
    always_comb begin
        tick       = (cnt_q == prescale_q);
        cnt_d      = tick ? '0 : cnt_q + CNT_ONE;
        prescale_d = prescale_q;
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        // A write to either mtime half suppresses this cycle's increment entirely,
        // so carry can never ripple into the freshly written half.
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        presc_wr   = merge32(32'(prescale_q), bus.wdata, bus.wmask);

        if (wr_ok) begin
            case (off)
                OFF_MSIP:   if (bus.wmask[0]) msip_d = bus.wdata[0];
                OFF_CMP_LO: mtimecmp_d[31:0]  = merge32(mtimecmp_q[31:0],  bus.wdata, bus.wmask);
                OFF_CMP_HI: mtimecmp_d[63:32] = merge32(mtimecmp_q[63:32], bus.wdata, bus.wmask);
                OFF_MT_LO:  mtime_d = {mtime_q[63:32], merge32(mtime_q[31:0],  bus.wdata, bus.wmask)};
                OFF_MT_HI:  mtime_d = {merge32(mtime_q[63:32], bus.wdata, bus.wmask), mtime_q[31:0]};
                OFF_PRESC: begin
                    prescale_d = presc_wr[PRESCALE_W-1:0];
                    cnt_d      = '0;
                end
                default: ;
            endcase
        end

        timer_irq_d = (mtime_q >= mtimecmp_q);
        soft_irq_d  = msip_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msip_q      <= 1'b0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            prescale_q  <= PRESCALE_W'(PRESCALE_RST);
            cnt_q       <= '0;
            timer_irq_q <= 1'b0;
            soft_irq_q  <= 1'b0;
        end else begin
            msip_q      <= msip_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            prescale_q  <= prescale_d;
            cnt_q       <= cnt_d;
            timer_irq_q <= timer_irq_d;
            soft_irq_q  <= soft_irq_d;
        end
    end

    assign bus.timer_irq = timer_irq_q;
    assign bus.soft_irq  = soft_irq_q;
endmodule
